// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product sequencer.
package dot_pkg;

    localparam int unsigned MUL_LAT    = 8;
    localparam int unsigned GUARD_INIT = 9;
    localparam int unsigned GUARD_W    = 4;
    localparam int unsigned PROD_W     = 17;
    localparam int unsigned OP_W       = 8;
    localparam int unsigned CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACC,
        DONE
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            last;
    } fifo_entry_t;

endpackage

// File: rtl/dot_fifo.sv
// Operand-pair FIFO with registered full/empty flags; DEPTH must be a power of 2.
module dot_fifo
    import dot_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t wr_data,
    input  logic        pop,
    output fifo_entry_t rd_data,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    // full is held high through reset so the producer sees back-pressure.
    always_ff @(posedge ck) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b1;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge ck) begin
        if (do_push) begin
            mem_q[wr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer driving an external 8x8 shift-add multiplier.
// Define DOT_SAT_EN for a saturating accumulator with a sticky out_sat flag.
module dot_seq
    import dot_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned TMO   = 12
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              err,
`ifdef DOT_SAT_EN
    output logic              out_sat,
`endif
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_start,
    input  logic [PROD_W-1:0] mul_o,
    input  logic              mul_fin
);

    localparam int unsigned TW = $clog2(TMO + 1);

    state_e             state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic               last_q, last_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               mul_start_q, mul_start_d;
`ifdef DOT_SAT_EN
    logic               sat_q, sat_d;
    logic [ACC_W:0]     sum_ext;
`endif

    fifo_entry_t wr_entry;
    fifo_entry_t head;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    assign wr_entry = '{a: in_a, b: in_b, last: in_last};

    dot_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck      (ck),
        .rst     (rst),
        .push    (in_valid),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        a_d         = a_q;
        b_d         = b_q;
        last_d      = last_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        fifo_pop    = 1'b0;
`ifdef DOT_SAT_EN
        sat_d       = sat_q;
        sum_ext     = '0;
`endif

        case (state_q)
            IDLE: begin
                // A high mul_fin here is stale; starting now would make mul misbehave.
                if (!fifo_empty && (guard_q == '0) && !mul_fin) begin
                    fifo_pop = 1'b1;
                    a_d      = head.a;
                    b_d      = head.b;
                    last_d   = head.last;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_fin) begin
                    prod_d  = mul_o;
                    state_d = ACC;
                end else if (tmo_q == TW'(TMO - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = ACC;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ACC: begin
`ifdef DOT_SAT_EN
                sum_ext = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
                if (sum_ext[ACC_W]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum_ext[ACC_W-1:0];
                end
`else
                acc_d = acc_q + ACC_W'(prod_q);
`endif
                cnt_d = cnt_q + CNT_W'(1);
                if (last_q) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = acc_d;
                    out_cnt_d   = cnt_d;
                    state_d     = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef DOT_SAT_EN
                    sat_d       = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        guard_d     = (guard_q != '0) ? guard_q - GUARD_W'(1) : guard_q;
        mul_start_d = (state_d == ISSUE);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= IDLE;
            guard_q     <= GUARD_W'(GUARD_INIT);
            tmo_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            last_q      <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            mul_start_q <= 1'b0;
`ifdef DOT_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            tmo_q       <= tmo_d;
            a_q         <= a_d;
            b_q         <= b_d;
            last_q      <= last_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            mul_start_q <= mul_start_d;
`ifdef DOT_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign in_ready  = !fifo_full;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign err       = err_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign mul_start = mul_start_q;
`ifdef DOT_SAT_EN
    assign out_sat   = sat_q;
`endif

endmodule

// File: tb/tb_dot_seq.sv
// Directed self-checking bench for dot_seq with a behavioural 8-cycle multiplier.
module tb_dot_seq;

    localparam int unsigned ACC_W = 17;

    logic             ck = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_cnt;
    logic             err;
`ifdef DOT_SAT_EN
    logic             out_sat;
`endif
    logic [7:0]       mul_a;
    logic [7:0]       mul_b;
    logic             mul_start;
    logic [16:0]      mul_o;
    logic             mul_fin;

    always #5 ck = ~ck;

    dot_seq #(
        .DEPTH (4),
        .ACC_W (ACC_W),
        .TMO   (12)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .err       (err),
`ifdef DOT_SAT_EN
        .out_sat   (out_sat),
`endif
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_o     (mul_o),
        .mul_fin   (mul_fin)
    );

    // Multiplier model: no reset, fin is a one-cycle pulse 8 cycles after start.
    logic        m_busy = 1'b0;
    logic [2:0]  m_cnt = '0;
    logic [16:0] m_o = '0;
    logic        mul_dead = 1'b0;

    always @(posedge ck) begin
        if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 3'd7;
            m_o    <= 17'(mul_a) * 17'(mul_b);
        end else if (m_busy) begin
            if (m_cnt == 3'd0) m_busy <= 1'b0;
            else               m_cnt  <= m_cnt - 3'd1;
        end
    end

    assign mul_fin = m_busy && (m_cnt == 3'd0) && !mul_dead;
    assign mul_o   = m_o;

    // Protocol monitor on the mul side port.
    int   viol = 0;
    int   since_rst = 0;
    int   first_gap = 0;
    bit   armed = 1'b0;
    logic fin_prev = 1'b0;
    logic start_prev = 1'b0;

    always @(posedge ck) begin
        if (rst) begin
            since_rst  <= 0;
            armed      <= 1'b1;
            fin_prev   <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            since_rst <= since_rst + 1;
            if (mul_start && armed) begin
                first_gap <= since_rst + 1;
                armed     <= 1'b0;
            end
            if (mul_start && (mul_fin || fin_prev || start_prev)) viol <= viol + 1;
            fin_prev   <= mul_fin;
            start_prev <= mul_start;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic last, input bit hold);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 400 && !in_ready; i++) tick();
        if (!in_ready) check("push_tmo", 32'(in_ready), 1);
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 400 && !out_valid; i++) tick();
        if (!out_valid) check({tag, "_tmo"}, 32'(out_valid), 1);
    endtask

    task automatic take(input string tag, input logic [31:0] sum, input logic [31:0] cnt);
        wait_valid(tag);
        check({tag, "_sum"}, 32'(out_sum), sum);
        check({tag, "_cnt"}, 32'(out_cnt), cnt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vclr"}, 32'(out_valid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_cnt", 32'(out_cnt), 0);
        check("rst_err", 32'(err), 0);
        check("rst_mul_start", 32'(mul_start), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 1);

        // 3*4 + 5*6 + 7*8 = 98, then stall in DONE for 20 cycles
        push(8'd3, 8'd4, 1'b0, 1'b0);
        push(8'd5, 8'd6, 1'b0, 1'b0);
        push(8'd7, 8'd8, 1'b1, 1'b0);
        wait_valid("a");
        check("a_sum", 32'(out_sum), 98);
        check("a_cnt", 32'(out_cnt), 3);
        check("a_err", 32'(err), 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!out_valid || out_sum != 17'd98 || out_cnt != 8'd3) bad++;
        end
        check("a_hold", 32'(bad), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("a_vclr", 32'(out_valid), 0);

        // Fill the FIFO while stalled in DONE, then drain in order
        push(8'd1, 8'd1, 1'b1, 1'b0);
        wait_valid("b_stall");
        check("b_stall_sum", 32'(out_sum), 1);
        push(8'd2, 8'd3, 1'b0, 1'b1);
        push(8'd4, 8'd5, 1'b1, 1'b1);
        push(8'd6, 8'd7, 1'b1, 1'b1);
        push(8'd8, 8'd9, 1'b0, 1'b1);
        check("b_full", 32'(in_ready), 0);
        fork
            push(8'd10, 8'd11, 1'b1, 1'b0);
            begin
                take("b0", 1, 1);
                take("b1", 26, 2);
                take("b2", 42, 1);
                take("b3", 182, 2);
            end
        join

        // Three 255*255 terms overflow a 17-bit accumulator
        push(8'd255, 8'd255, 1'b0, 1'b0);
        push(8'd255, 8'd255, 1'b0, 1'b0);
        push(8'd255, 8'd255, 1'b1, 1'b0);
        wait_valid("c");
`ifdef DOT_SAT_EN
        check("c_sat", 32'(out_sat), 1);
        take("c", 131071, 3);
        check("c_sat_clr", 32'(out_sat), 0);
`else
        take("c", 64003, 3);
`endif

        // Multiplier never finishes: timeout sets sticky err
        mul_dead = 1'b1;
        push(8'd9, 8'd9, 1'b1, 1'b0);
        wait_valid("d");
        check("d_err", 32'(err), 1);
        take("d", 0, 1);
        mul_dead = 1'b0;
        push(8'd2, 8'd2, 1'b1, 1'b0);
        take("d_next", 4, 1);
        check("d_err_sticky", 32'(err), 1);

        // Reset while in WAIT; the multiplier keeps running and fires later
        push(8'd5, 8'd5, 1'b1, 1'b0);
        for (int i = 0; i < 100 && !mul_start; i++) tick();
        check("e_start_seen", 32'(mul_start), 1);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        check("e_rst_in_ready", 32'(in_ready), 0);
        check("e_rst_out_valid", 32'(out_valid), 0);
        check("e_rst_err", 32'(err), 0);
        check("e_rst_mul_start", 32'(mul_start), 0);
        check("e_rst_mul_a", 32'(mul_a), 0);
        check("e_rst_out_sum", 32'(out_sum), 0);
        check("e_rst_out_cnt", 32'(out_cnt), 0);
        rst = 1'b0;
        tick();
        check("e_in_ready", 32'(in_ready), 1);
        push(8'd2, 8'd3, 1'b1, 1'b0);
        take("e", 6, 1);
        check("e_guard_gap", 32'(first_gap >= 10), 1);
        check("e_err", 32'(err), 0);

        check("mul_protocol", 32'(viol), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dot_seq.md
Name: dot_seq

Overview:
- Dot-product sequencer wrapped around the 8x8 shift-add multiplier (mul).
- Buffers operand pairs in a small FIFO and issues each pair to mul with a one-cycle start pulse.
- Captures the 17-bit product on fin and accumulates it. On the pair tagged last, presents sum and term count through a valid/ready output.
- Upstream: operand producer. Downstream: result consumer. Side port: one mul instance.

Parameters:
- DEPTH, 4: operand FIFO entries; must be a power of 2, at least 2.
- ACC_W, 24: accumulator width; must be at least 17.
- TMO, 12: maximum WAIT cycles for mul_fin before timeout.

Ports:
- ck  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- in_last  in  1  final term of the current dot product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  accumulated sum.
- out_cnt  out  8  number of terms (wraps modulo 256).
- err  out  1  sticky mul timeout flag.
- mul_a  out  8  to mul A.
- mul_b  out  8  to mul B.
- mul_start  out  1  to mul start.
- mul_o  in  17  from mul O.
- mul_fin  in  1  from mul fin.

Behaviour:
- Reset values: in_ready=0 during rst, then 1; out_valid=0; out_sum=0; out_cnt=0; err=0; mul_start=0; mul_a=0; mul_b=0; FIFO empty; guard=9; state=IDLE.
- FIFO: a push occurs when in_valid and in_ready. in_ready = !full. A pop occurs only on the IDLE->ISSUE transition. Push and pop in the same cycle are legal.
- Guard counter: after reset it counts 9 down to 0. No issue while guard!=0. This lets a mul left running through a reset finish; mul itself has no reset.
- IDLE:
  - Go to ISSUE if the FIFO is non-empty, guard==0 and mul_fin==0.
  - Pop the head into the a/b/last registers; drive mul_a/mul_b from them.
- ISSUE:
  - mul_start=1 for exactly this one cycle; mul_a/mul_b are stable.
  - Next state WAIT; clear the timeout counter.
- WAIT:
  - If mul_fin==1: capture mul_o into the prod register, go to ACC.
  - Else if the timeout counter reaches TMO: prod=0, err<=1, go to ACC.
  - mul_fin is ignored in every state except WAIT.
  - Nominal fin arrives 8 cycles after the ISSUE edge, so WAIT lasts 8 cycles.
- ACC:
  - acc <= acc + zero-extended prod (modulo 2^ACC_W); cnt <= cnt+1.
  - Next state DONE if last, else IDLE.
  - ACC guarantees mul_fin has dropped before any new start. mul_start is never asserted in a cycle where mul_fin==1 (mul would raise a spurious fin with O=0).
- DONE:
  - out_valid=1; out_sum=acc; out_cnt=cnt.
  - Hold until out_ready. On the handshake cycle clear acc and cnt, set out_valid<=0, go to IDLE.
  - The FIFO continues to accept pushes while in DONE.
- Throughput: 11 cycles per term (IDLE, ISSUE, 8 WAIT, ACC), plus DONE.
- Reset mid-operation: all state is cleared. A stray mul_fin after reset is ignored (state is not WAIT, and guard blocks issue).
- err clears only on rst.

Optional Feature:
- Macro: DOT_SAT_EN.
- Defined: the ACC addition saturates at 2^ACC_W-1. A sticky out_sat bit (extra output port) is set for the current result and cleared on the DONE handshake.
- Undefined: the sum wraps modulo 2^ACC_W and no out_sat port exists.

Decomposition:
- Package dot_pkg:
  - state enum {IDLE, ISSUE, WAIT, ACC, DONE};
  - MUL_LAT=8, GUARD_INIT=9, PROD_W=17, OP_W=8;
  - fifo entry struct {a, b, last}.
- Sub-module dot_fifo: DEPTH-entry synchronous FIFO with full/empty flags and pointer wrap.
- The top-level instantiates dot_fifo. mul sits outside, connected through the mul_* ports.

Test Plan:
- Pairs (3,4),(5,6),(7,8,last) with a real mul -> out_valid, out_sum=98, out_cnt=3, err=0. Each mul_start lasts 1 cycle; the next start comes at least 1 cycle after fin.
- Push 5 pairs back-to-back with DEPTH=4 while the block is stalled in DONE (out_ready=0) -> in_ready drops after the 4th push. With out_ready=1, results appear in order and no pair is lost.
- ACC_W=17, three terms (255,255) -> without DOT_SAT_EN out_sum=64003; with DOT_SAT_EN out_sum=131071 and out_sat=1.
- mul model never asserts fin, single pair last -> after TMO WAIT cycles err=1, out_sum=0, out_cnt=1; err stays 1 across later operations until rst.
- rst asserted mid-WAIT, mul keeps running and fires fin ~5 cycles later -> outputs return to reset values. The stray fin is ignored. The first new mul_start occurs no earlier than 9 cycles after rst deasserts and not in a cycle with mul_fin=1.
- out_ready held 0 for 20 cycles in DONE -> out_sum/out_cnt stay stable. The handshake clears acc, and the next result starts from 0.
